// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared AXI4 read-address types and constants
package axi4_pkg;

   // AXI4 burst encodings; 2'b11 is reserved
   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } axi_burst_e;

   // AR generator FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_ADDR = 2'd2
   } ar_state_e;

   localparam int AXI4_BOUNDARY_BYTES  = 4096;
   localparam int AXI4_FIXED_MAX_BEATS = 16;

endpackage

// File: rtl/axi4_rd_burst_splitter.sv
// rtl/axi4_rd_burst_splitter.sv - burst size/next address calc; AXI_RD_4K_SPLIT_EN adds 4 KB split
module axi4_rd_burst_splitter
   import axi4_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int BURST_LENGTH    = 8,
   parameter int CMD_BEATS_WIDTH = 16
) (
   input  logic [ADDR_WIDTH-1:0]      cur_addr,
   input  logic [CMD_BEATS_WIDTH-1:0] remaining,
   input  logic [2:0]                 size,
   input  logic [1:0]                 burst,
   output logic [CMD_BEATS_WIDTH-1:0] this_beats,
   output logic [ADDR_WIDTH-1:0]      next_addr
);

   // Wide enough for remaining, 2^BURST_LENGTH and a full 4 KB page of bytes
   localparam int CW = 32;

   logic [CW-1:0]         rem_w;
   logic [CW-1:0]         cap_w;
   logic [CW-1:0]         lim_w;
   logic [CW-1:0]         beats_w;
   logic [ADDR_WIDTH-1:0] size_mask;
   logic [ADDR_WIDTH-1:0] aligned;

   // this_beats = min(remaining, cap, page limit); INCR advances from the aligned address
   always_comb begin
      rem_w     = CW'(remaining);
      size_mask = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
      aligned   = cur_addr & ~size_mask;
      case (burst)
         BURST_INCR: cap_w = CW'(1) << BURST_LENGTH;
         BURST_WRAP: cap_w = rem_w;
         default:    cap_w = CW'(AXI4_FIXED_MAX_BEATS);
      endcase
`ifdef AXI_RD_4K_SPLIT_EN
      // Beats left before the next 4 KB page, counted from the aligned start
      lim_w = (burst == BURST_INCR)
            ? CW'((13'(AXI4_BOUNDARY_BYTES) - {1'b0, aligned[11:0]}) >> size)
            : '1;
`else
      lim_w = '1;
`endif
      beats_w = (rem_w < cap_w) ? rem_w : cap_w;
      if (lim_w < beats_w) beats_w = lim_w;
      this_beats = beats_w[CMD_BEATS_WIDTH-1:0];
      next_addr  = (burst == BURST_INCR) ? aligned + ADDR_WIDTH'(beats_w << size) : cur_addr;
   end

endmodule

// File: rtl/axi4_master_read_address.sv
// rtl/axi4_master_read_address.sv - AXI4 AR channel generator; AXI_RD_4K_SPLIT_EN enables 4 KB split
module axi4_master_read_address
   import axi4_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int ID_WIDTH        = 4,
   parameter int BURST_LENGTH    = 8,
   parameter int CMD_BEATS_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [ADDR_WIDTH-1:0]      cmd_addr,
   input  logic [ID_WIDTH-1:0]        cmd_id,
   input  logic [CMD_BEATS_WIDTH-1:0] cmd_beats,
   input  logic [2:0]                 cmd_size,
   input  logic [1:0]                 cmd_burst,
   output logic                       arvalid,
   output logic [ADDR_WIDTH-1:0]      araddr,
   output logic [ID_WIDTH-1:0]        arid,
   output logic [BURST_LENGTH-1:0]    arlen,
   output logic [2:0]                 arsize,
   output logic [1:0]                 arburst,
   input  logic                       arready,
   output logic                       busy,
   output logic                       ar_issued,
   output logic                       cmd_done
);

   ar_state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]      cur_addr_q, cur_addr_d;
   logic [CMD_BEATS_WIDTH-1:0] remaining_q, remaining_d;
   logic [ID_WIDTH-1:0]        id_q, id_d;
   logic [2:0]                 size_q, size_d;
   logic [1:0]                 burst_q, burst_d;
   logic [CMD_BEATS_WIDTH-1:0] beats_q, beats_d;
   logic [ADDR_WIDTH-1:0]      next_addr_q, next_addr_d;

   logic                       cmd_ready_d, arvalid_d, busy_d, ar_issued_d, cmd_done_d;
   logic [ADDR_WIDTH-1:0]      araddr_d;
   logic [ID_WIDTH-1:0]        arid_d;
   logic [BURST_LENGTH-1:0]    arlen_d;
   logic [2:0]                 arsize_d;
   logic [1:0]                 arburst_d;

   logic [CMD_BEATS_WIDTH-1:0] split_beats;
   logic [ADDR_WIDTH-1:0]      split_next;
   logic [CMD_BEATS_WIDTH-1:0] rem_after;

   axi4_rd_burst_splitter #(
      .ADDR_WIDTH      (ADDR_WIDTH),
      .BURST_LENGTH    (BURST_LENGTH),
      .CMD_BEATS_WIDTH (CMD_BEATS_WIDTH)
   ) u_splitter (
      .cur_addr   (cur_addr_q),
      .remaining  (remaining_q),
      .size       (size_q),
      .burst      (burst_q),
      .this_beats (split_beats),
      .next_addr  (split_next)
   );

   assign rem_after = remaining_q - beats_q;

   // Next-state and next-output logic; every output is a registered copy of these
   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      id_d        = id_q;
      size_d      = size_q;
      burst_d     = burst_q;
      beats_d     = beats_q;
      next_addr_d = next_addr_q;
      arvalid_d   = arvalid;
      araddr_d    = araddr;
      arid_d      = arid;
      arlen_d     = arlen;
      arsize_d    = arsize;
      arburst_d   = arburst;
      ar_issued_d = 1'b0;
      cmd_done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               cur_addr_d  = cmd_addr;
               remaining_d = cmd_beats;
               id_d        = cmd_id;
               size_d      = cmd_size;
               burst_d     = cmd_burst;
               if (cmd_beats == '0) begin
                  cmd_done_d = 1'b1;
               end else begin
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            // Next address is captured now so ADDR only has to commit it
            beats_d     = split_beats;
            next_addr_d = split_next;
            araddr_d    = cur_addr_q;
            arlen_d     = BURST_LENGTH'(split_beats - CMD_BEATS_WIDTH'(1));
            arid_d      = id_q;
            arsize_d    = size_q;
            arburst_d   = burst_q;
            arvalid_d   = 1'b1;
            state_d     = ST_ADDR;
         end
         ST_ADDR: begin
            if (arvalid && arready) begin
               arvalid_d   = 1'b0;
               ar_issued_d = 1'b1;
               remaining_d = rem_after;
               cur_addr_d  = next_addr_q;
               if (rem_after == '0) begin
                  state_d    = ST_IDLE;
                  cmd_done_d = 1'b1;
               end else begin
                  state_d = ST_CALC;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
   end

   // State, command context and registered outputs; reset discards any command
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         id_q        <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         beats_q     <= '0;
         next_addr_q <= '0;
         cmd_ready   <= 1'b0;
         arvalid     <= 1'b0;
         araddr      <= '0;
         arid        <= '0;
         arlen       <= '0;
         arsize      <= '0;
         arburst     <= '0;
         busy        <= 1'b0;
         ar_issued   <= 1'b0;
         cmd_done    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         id_q        <= id_d;
         size_q      <= size_d;
         burst_q     <= burst_d;
         beats_q     <= beats_d;
         next_addr_q <= next_addr_d;
         cmd_ready   <= cmd_ready_d;
         arvalid     <= arvalid_d;
         araddr      <= araddr_d;
         arid        <= arid_d;
         arlen       <= arlen_d;
         arsize      <= arsize_d;
         arburst     <= arburst_d;
         busy        <= busy_d;
         ar_issued   <= ar_issued_d;
         cmd_done    <= cmd_done_d;
      end
   end

endmodule

// File: tb/tb_axi4_master_read_address.sv
// tb/tb_axi4_master_read_address.sv - directed self-checking bench for axi4_master_read_address
module tb_axi4_master_read_address;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_addr = '0;
   logic [3:0]  cmd_id = '0;
   logic [15:0] cmd_beats = '0;
   logic [2:0]  cmd_size = '0;
   logic [1:0]  cmd_burst = '0;
   logic        arvalid;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arready = 1'b0;
   logic        busy;
   logic        ar_issued;
   logic        cmd_done;

   int n_vec = 0;
   int n_bad = 0;

   axi4_master_read_address dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_id    (cmd_id),
      .cmd_beats (cmd_beats),
      .cmd_size  (cmd_size),
      .cmd_burst (cmd_burst),
      .arvalid   (arvalid),
      .araddr    (araddr),
      .arid      (arid),
      .arlen     (arlen),
      .arsize    (arsize),
      .arburst   (arburst),
      .arready   (arready),
      .busy      (busy),
      .ar_issued (ar_issued),
      .cmd_done  (cmd_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  id;
      logic [15:0] beats;
      logic [2:0]  size;
      logic [1:0]  burst;
      int          n_ar;
      logic [31:0] a0;
      logic [7:0]  l0;
      logic [31:0] a1;
      logic [7:0]  l1;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic [31:0] addr, input logic [3:0] id,
                          input logic [15:0] beats, input logic [2:0] size, input logic [1:0] burst,
                          input int n, input logic [31:0] a0, input logic [7:0] l0,
                          input logic [31:0] a1, input logic [7:0] l1);
      vecs[i].addr = addr;  vecs[i].id = id;  vecs[i].beats = beats;
      vecs[i].size = size;  vecs[i].burst = burst; vecs[i].n_ar = n;
      vecs[i].a0 = a0; vecs[i].l0 = l0; vecs[i].a1 = a1; vecs[i].l1 = l1;
   endtask

   // Drive one command; returns at the falling edge after the accepting edge
   task automatic drive_cmd(input logic [31:0] addr, input logic [3:0] id, input logic [15:0] beats,
                            input logic [2:0] size, input logic [1:0] burst);
      int w = 0;
      while (!cmd_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("cmd_ready_before_cmd", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_addr = addr; cmd_id = id;
      cmd_beats = beats; cmd_size = size; cmd_burst = burst;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_arvalid(output int cnt);
      cnt = 0;
      while (!arvalid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   task automatic run_vec(input int i);
      int cnt;
      logic [31:0] ea;
      logic [7:0]  el;
      arready = 1'b1;
      drive_cmd(vecs[i].addr, vecs[i].id, vecs[i].beats, vecs[i].size, vecs[i].burst);
      chk($sformatf("v%0d_ready_low", i), cmd_ready, 0);
      chk($sformatf("v%0d_busy", i), busy, 1);
      for (int k = 0; k < vecs[i].n_ar; k++) begin
         ea = (k == 0) ? vecs[i].a0 : vecs[i].a1;
         el = (k == 0) ? vecs[i].l0 : vecs[i].l1;
         wait_arvalid(cnt);
         chk($sformatf("v%0d_ar%0d_latency", i, k), cnt, 1);
         chk($sformatf("v%0d_ar%0d_araddr", i, k), araddr, ea);
         chk($sformatf("v%0d_ar%0d_arlen", i, k), arlen, el);
         chk($sformatf("v%0d_ar%0d_arid", i, k), arid, vecs[i].id);
         chk($sformatf("v%0d_ar%0d_arsize", i, k), arsize, vecs[i].size);
         chk($sformatf("v%0d_ar%0d_arburst", i, k), arburst, vecs[i].burst);
         @(negedge clk);
         chk($sformatf("v%0d_ar%0d_issued", i, k), ar_issued, 1);
         chk($sformatf("v%0d_ar%0d_arvalid_low", i, k), arvalid, 0);
         chk($sformatf("v%0d_ar%0d_cmd_done", i, k), cmd_done, (k == vecs[i].n_ar - 1) ? 1 : 0);
      end
      chk($sformatf("v%0d_ready_back", i), cmd_ready, 1);
      chk($sformatf("v%0d_busy_clear", i), busy, 0);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), cmd_done, 0);
      chk($sformatf("v%0d_no_extra_ar", i), arvalid, 0);
   endtask

   initial begin
      int cnt;
`ifdef AXI_RD_4K_SPLIT_EN
      set_vec(0, 32'h0000_0FF0, 4'h1, 16'd8, 3'd2, 2'b01, 2, 32'h0000_0FF0, 8'd3, 32'h0000_1000, 8'd3);
      set_vec(4, 32'h0000_0FFE, 4'h5, 16'd4, 3'd2, 2'b01, 2, 32'h0000_0FFE, 8'd0, 32'h0000_1000, 8'd2);
`else
      set_vec(0, 32'h0000_0FF0, 4'h1, 16'd8, 3'd2, 2'b01, 1, 32'h0000_0FF0, 8'd7, 32'h0, 8'd0);
      set_vec(4, 32'h0000_0FFE, 4'h5, 16'd4, 3'd2, 2'b01, 1, 32'h0000_0FFE, 8'd3, 32'h0, 8'd0);
`endif
      set_vec(1, 32'h1000_0000, 4'h2, 16'd300, 3'd3, 2'b01, 2, 32'h1000_0000, 8'd255, 32'h1000_0800, 8'd43);
      set_vec(2, 32'h2000_0004, 4'h3, 16'd20, 3'd2, 2'b00, 2, 32'h2000_0004, 8'd15, 32'h2000_0004, 8'd3);
      set_vec(3, 32'h0000_0040, 4'h4, 16'd4, 3'd2, 2'b10, 1, 32'h0000_0040, 8'd3, 32'h0, 8'd0);
      set_vec(5, 32'h3000_0000, 4'h6, 16'd257, 3'd0, 2'b01, 2, 32'h3000_0000, 8'd255, 32'h3000_0100, 8'd0);

      // Reset state, and cmd_ready rising on the first edge after release
      repeat (3) @(negedge clk);
      chk("reset_outputs", {cmd_ready, arvalid, araddr, arid, arlen, arsize, arburst, busy, ar_issued, cmd_done}, 0);
      rst = 1'b1;
      #1;
      chk("ready_before_first_edge", cmd_ready, 0);
      @(negedge clk);
      chk("ready_after_first_edge", cmd_ready, 1);

      for (int i = 0; i < 6; i++) run_vec(i);

      // Backpressure: payload held, second command held off, one ar_issued
      arready = 1'b0;
      drive_cmd(32'h5000_0000, 4'h9, 16'd4, 3'd2, 2'b01);
      wait_arvalid(cnt);
      chk("bp_latency", cnt, 1);
      cmd_valid = 1'b1; cmd_addr = 32'h7000_0000; cmd_beats = 16'd1;
      for (int c = 0; c < 5; c++) begin
         chk("bp_arvalid_held", arvalid, 1);
         chk("bp_payload_held", {araddr, arid, arlen, arsize, arburst}, {32'h5000_0000, 4'h9, 8'd3, 3'd2, 2'b01});
         chk("bp_no_issue", ar_issued, 0);
         chk("bp_ready_low", cmd_ready, 0);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      arready = 1'b1;
      @(negedge clk);
      chk("bp_issued", ar_issued, 1);
      chk("bp_done", cmd_done, 1);
      chk("bp_arvalid_low", arvalid, 0);
      @(negedge clk);
      chk("bp_issue_pulse", ar_issued, 0);
      chk("bp_idle", busy, 0);

      // Zero-beat command: done in the next cycle, no AR
      drive_cmd(32'h0000_1234, 4'h7, 16'd0, 3'd2, 2'b01);
      chk("zero_done", cmd_done, 1);
      chk("zero_no_ar", arvalid, 0);
      chk("zero_ready", cmd_ready, 1);
      chk("zero_not_busy", busy, 0);
      @(negedge clk);
      chk("zero_done_pulse", cmd_done, 0);
      chk("zero_still_no_ar", arvalid, 0);
      run_vec(3);

      // Reset while an AR is pending
      arready = 1'b0;
      drive_cmd(32'h6000_0000, 4'h3, 16'd600, 3'd2, 2'b01);
      wait_arvalid(cnt);
      chk("mid_arvalid", arvalid, 1);
      #2 rst = 1'b0;
      #1;
      chk("mid_reset_outputs", {cmd_ready, arvalid, araddr, arid, arlen, arsize, arburst, busy, ar_issued, cmd_done}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_ready_after", cmd_ready, 1);
      chk("mid_idle_after", {busy, arvalid}, 0);
      run_vec(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
